// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths and constants for the 5-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int CTRL_W = 16;

    localparam logic [AW-1:0]     REG_ZERO    = '0;
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Priority operand bypass mux (r0, EX, MEM, WB, register file).
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
    import pipe_pkg::*;
#(
    parameter int DW = pipe_pkg::DW,
    parameter int AW = pipe_pkg::AW
) (
    input  logic [AW-1:0] i_idx,
    input  logic [DW-1:0] i_rfData,
    input  logic          i_exHit,
    input  logic [AW-1:0] i_exWr,
    input  logic [DW-1:0] i_exData,
    input  logic          i_memWe,
    input  logic [AW-1:0] i_memWr,
    input  logic [DW-1:0] i_memData,
    input  logic          i_wbWe,
    input  logic [AW-1:0] i_wbWr,
    input  logic [DW-1:0] i_wbData,
    output logic [DW-1:0] o_data
);

    always_comb begin
        o_data = i_rfData;
        // Youngest producer wins; r0 is hard-wired regardless of writers.
        if (i_idx == AW'(REG_ZERO)) begin
            o_data = '0;
        end else if (i_exHit && (i_exWr == i_idx)) begin
            o_data = i_exData;
        end else if (i_memWe && (i_memWr == i_idx)) begin
            o_data = i_memData;
        end else if (i_wbWe && (i_wbWr == i_idx)) begin
            o_data = i_wbData;
        end
    end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Operand bypass, load-use detection and ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
#(
    parameter int DW     = pipe_pkg::DW,
    parameter int AW     = pipe_pkg::AW,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DW-1:0]     id_pc,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [AW-1:0]     id_rR1,
    input  logic [AW-1:0]     id_rR2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic [DW-1:0]     id_rD1,
    input  logic [DW-1:0]     id_rD2,
    input  logic [AW-1:0]     id_wR,
    input  logic              id_we,
    input  logic              id_is_load,
    input  logic [DW-1:0]     ex_aluD,
    input  logic              mem_we,
    input  logic [AW-1:0]     mem_wR,
    input  logic [DW-1:0]     mem_wD,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_wR,
    input  logic [DW-1:0]     wb_wD,
    input  logic              ex_flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [DW-1:0]     ex_pc,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [DW-1:0]     ex_rD1,
    output logic [DW-1:0]     ex_rD2,
    output logic [AW-1:0]     ex_wR,
    output logic              ex_we,
    output logic              ex_is_load
);

    import pipe_pkg::*;

    logic              r_exValid;
    logic [DW-1:0]     r_exPc;
    logic [CTRL_W-1:0] r_exCtrl;
    logic [DW-1:0]     r_exRD1;
    logic [DW-1:0]     r_exRD2;
    logic [AW-1:0]     r_exWR;
    logic              r_exWe;
    logic              r_exIsLoad;

    logic          w_exFwdOk;
    logic          w_loadUse;
    logic          w_stall;
    logic          w_bubble;
    logic [DW-1:0] w_opA;
    logic [DW-1:0] w_opB;

    // A load's data is not ready in EX; those consumers stall instead.
    assign w_exFwdOk = r_exValid & r_exWe & ~r_exIsLoad;

    assign w_loadUse = id_valid & r_exValid & r_exWe & r_exIsLoad
                     & (r_exWR != AW'(REG_ZERO))
                     & ((id_use1 & (id_rR1 == r_exWR)) | (id_use2 & (id_rR2 == r_exWR)));

    assign w_stall  = w_loadUse & ~ex_flush;
    assign w_bubble = ex_flush | w_stall;

    fwd_mux #(.DW(DW), .AW(AW)) u_fwdRs (
        .i_idx     (id_rR1),
        .i_rfData  (id_rD1),
        .i_exHit   (w_exFwdOk),
        .i_exWr    (r_exWR),
        .i_exData  (ex_aluD),
        .i_memWe   (mem_we),
        .i_memWr   (mem_wR),
        .i_memData (mem_wD),
        .i_wbWe    (wb_we),
        .i_wbWr    (wb_wR),
        .i_wbData  (wb_wD),
        .o_data    (w_opA)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwdRt (
        .i_idx     (id_rR2),
        .i_rfData  (id_rD2),
        .i_exHit   (w_exFwdOk),
        .i_exWr    (r_exWR),
        .i_exData  (ex_aluD),
        .i_memWe   (mem_we),
        .i_memWr   (mem_wR),
        .i_memData (mem_wD),
        .i_wbWe    (wb_we),
        .i_wbWr    (wb_wR),
        .i_wbData  (wb_wD),
        .o_data    (w_opB)
    );

    always_ff @(posedge clk) begin
        if (rst || w_bubble) begin
            r_exValid  <= 1'b0;
            r_exPc     <= '0;
            r_exCtrl   <= CTRL_W'(CTRL_BUBBLE);
            r_exRD1    <= '0;
            r_exRD2    <= '0;
            r_exWR     <= '0;
            r_exWe     <= 1'b0;
            r_exIsLoad <= 1'b0;
        end else begin
            r_exValid  <= id_valid;
            r_exPc     <= id_pc;
            r_exCtrl   <= id_ctrl;
            r_exRD1    <= w_opA;
            r_exRD2    <= w_opB;
            r_exWR     <= id_wR;
            r_exWe     <= id_we & id_valid & (id_wR != AW'(REG_ZERO));
            r_exIsLoad <= id_is_load & id_valid;
        end
    end

    assign stall      = w_stall;
    assign ex_valid   = r_exValid;
    assign ex_pc      = r_exPc;
    assign ex_ctrl    = r_exCtrl;
    assign ex_rD1     = r_exRD1;
    assign ex_rD2     = r_exRD2;
    assign ex_wR      = r_exWR;
    assign ex_we      = r_exWe;
    assign ex_is_load = r_exIsLoad;

endmodule : id_ex_stage
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage bypass, hazard and register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [15:0] id_ctrl;
    logic [4:0]  id_rR1, id_rR2;
    logic        id_use1, id_use2;
    logic [31:0] id_rD1, id_rD2;
    logic [4:0]  id_wR;
    logic        id_we, id_is_load;
    logic [31:0] ex_aluD;
    logic        mem_we;
    logic [4:0]  mem_wR;
    logic [31:0] mem_wD;
    logic        wb_we;
    logic [4:0]  wb_wR;
    logic [31:0] wb_wD;
    logic        ex_flush;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [15:0] ex_ctrl;
    logic [31:0] ex_rD1, ex_rD2;
    logic [4:0]  ex_wR;
    logic        ex_we, ex_is_load;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  wR;
        logic        we;
        logic        ld;
    } exp_t;

    exp_t q_exp[$];
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .id_rR1(id_rR1), .id_rR2(id_rR2), .id_use1(id_use1), .id_use2(id_use2),
        .id_rD1(id_rD1), .id_rD2(id_rD2), .id_wR(id_wR), .id_we(id_we),
        .id_is_load(id_is_load), .ex_aluD(ex_aluD),
        .mem_we(mem_we), .mem_wR(mem_wR), .mem_wD(mem_wD),
        .wb_we(wb_we), .wb_wR(wb_wR), .wb_wD(wb_wD),
        .ex_flush(ex_flush), .stall(stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ctrl(ex_ctrl),
        .ex_rD1(ex_rD1), .ex_rD2(ex_rD2), .ex_wR(ex_wR),
        .ex_we(ex_we), .ex_is_load(ex_is_load)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clrSide();
        rst = 1'b0; ex_flush = 1'b0; ex_aluD = '0;
        mem_we = 1'b0; mem_wR = '0; mem_wD = '0;
        wb_we = 1'b0; wb_wR = '0; wb_wD = '0;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                       input logic [4:0] r1, input logic [31:0] d1, input logic u1,
                       input logic [4:0] r2, input logic [31:0] d2, input logic u2,
                       input logic [4:0] wR, input logic we, input logic ld);
        id_valid = v; id_pc = pc; id_ctrl = ctrl;
        id_rR1 = r1; id_rD1 = d1; id_use1 = u1;
        id_rR2 = r2; id_rD2 = d2; id_use2 = u2;
        id_wR = wR; id_we = we; id_is_load = ld;
    endtask

    task automatic pushExp(input logic v, input logic [31:0] pc, input logic [15:0] ctrl,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [4:0] wR, input logic we, input logic ld);
        exp_t e;
        e.v = v; e.pc = pc; e.ctrl = ctrl; e.d1 = d1; e.d2 = d2;
        e.wR = wR; e.we = we; e.ld = ld;
        q_exp.push_back(e);
    endtask

    task automatic pushBubble();
        pushExp(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Inputs are already driven; check combinational stall, clock, then score.
    task automatic tick(input string tag, input logic expStall);
        exp_t e;
        #2;
        chk({tag, ".stall"}, 64'(stall), 64'(expStall));
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            chk({tag, ".queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = q_exp.pop_front();
            chk({tag, ".ex_valid"},   64'(ex_valid),   64'(e.v));
            chk({tag, ".ex_pc"},      64'(ex_pc),      64'(e.pc));
            chk({tag, ".ex_ctrl"},    64'(ex_ctrl),    64'(e.ctrl));
            chk({tag, ".ex_rD1"},     64'(ex_rD1),     64'(e.d1));
            chk({tag, ".ex_rD2"},     64'(ex_rD2),     64'(e.d2));
            chk({tag, ".ex_wR"},      64'(ex_wR),      64'(e.wR));
            chk({tag, ".ex_we"},      64'(ex_we),      64'(e.we));
            chk({tag, ".ex_is_load"}, 64'(ex_is_load), 64'(e.ld));
        end
    endtask

    initial begin
        clrSide();
        drv(1'b1, 32'hDEAD, 16'hBEEF, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 1'b1, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        pushBubble();
        tick("reset", 1'b0);

        // No hazard
        clrSide();
        drv(1'b1, 32'h100, 16'h1234, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 5'd5, 1'b1, 1'b0);
        pushExp(1'b1, 32'h100, 16'h1234, 32'h11, 32'h22, 5'd5, 1'b1, 1'b0);
        tick("nohaz", 1'b0);

        // EX, MEM and WB all write r5: EX wins; r0 source reads zero
        clrSide();
        ex_aluD = 32'hA;
        mem_we = 1'b1; mem_wR = 5'd5; mem_wD = 32'hB;
        wb_we  = 1'b1; wb_wR  = 5'd5; wb_wD  = 32'hC;
        drv(1'b1, 32'h104, 16'h0001, 5'd5, 32'h55, 1'b1, 5'd0, 32'h77, 1'b1, 5'd6, 1'b1, 1'b0);
        pushExp(1'b1, 32'h104, 16'h0001, 32'hA, 32'h0, 5'd6, 1'b1, 1'b0);
        tick("fwd_ex", 1'b0);

        // EX now writes r6: r5 comes from MEM, r6 from EX; id_wR=0 suppresses ex_we
        clrSide();
        ex_aluD = 32'hD;
        mem_we = 1'b1; mem_wR = 5'd5; mem_wD = 32'hB;
        wb_we  = 1'b1; wb_wR  = 5'd5; wb_wD  = 32'hC;
        drv(1'b1, 32'h108, 16'h0002, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b1, 5'd0, 1'b1, 1'b0);
        pushExp(1'b1, 32'h108, 16'h0002, 32'hB, 32'hD, 5'd0, 1'b0, 1'b0);
        tick("fwd_mem", 1'b0);

        // Only WB writes r5 (same-cycle write/read): new value; issue lw r7
        clrSide();
        ex_aluD = 32'h5A5A;
        mem_we = 1'b1; mem_wR = 5'd7; mem_wD = 32'hEE;
        wb_we  = 1'b1; wb_wR  = 5'd5; wb_wD  = 32'hC;
        drv(1'b1, 32'h10C, 16'h0003, 5'd5, 32'h55, 1'b1, 5'd9, 32'h99A, 1'b1, 5'd7, 1'b1, 1'b1);
        pushExp(1'b1, 32'h10C, 16'h0003, 32'hC, 32'h99A, 5'd7, 1'b1, 1'b1);
        tick("fwd_wb", 1'b0);

        // Load-use on r7: stall and bubble
        clrSide();
        ex_aluD = 32'h1234;
        drv(1'b1, 32'h110, 16'h0004, 5'd7, 32'h70, 1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 1'b1, 1'b0);
        pushBubble();
        tick("lu_stall", 1'b1);

        // Load now in MEM: operand bypassed from MEM, no stall
        clrSide();
        mem_we = 1'b1; mem_wR = 5'd7; mem_wD = 32'h99;
        pushExp(1'b1, 32'h110, 16'h0004, 32'h99, 32'h22, 5'd8, 1'b1, 1'b0);
        tick("lu_release", 1'b0);

        // Writes to r0 are never forwarded; issue lw r9
        clrSide();
        mem_we = 1'b1; mem_wR = 5'd0; mem_wD = 32'hFF;
        wb_we  = 1'b1; wb_wR  = 5'd0; wb_wD  = 32'hFF;
        drv(1'b1, 32'h114, 16'h0005, 5'd0, 32'h33, 1'b1, 5'd0, 32'h44, 1'b1, 5'd9, 1'b1, 1'b1);
        pushExp(1'b1, 32'h114, 16'h0005, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1);
        tick("r0_guard", 1'b0);

        // Flush together with load-use on r9: no stall, bubble
        clrSide();
        ex_flush = 1'b1;
        drv(1'b1, 32'h118, 16'h0006, 5'd9, 32'h90, 1'b1, 5'd1, 32'h10, 1'b1, 5'd4, 1'b1, 1'b0);
        pushBubble();
        tick("flush_lu", 1'b0);

        // Invalid ID: fields pass, but no valid/we/load
        clrSide();
        drv(1'b0, 32'h11C, 16'h0007, 5'd3, 32'h5, 1'b1, 5'd4, 32'h6, 1'b1, 5'd3, 1'b1, 1'b1);
        pushExp(1'b0, 32'h11C, 16'h0007, 32'h5, 32'h6, 5'd3, 1'b0, 1'b0);
        tick("invalid_id", 1'b0);

        // lw r10 into EX
        clrSide();
        drv(1'b1, 32'h120, 16'h0008, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 1'b1, 1'b1);
        pushExp(1'b1, 32'h120, 16'h0008, 32'h1, 32'h2, 5'd10, 1'b1, 1'b1);
        tick("lw_r10", 1'b0);

        // Invalid ID reading r10 behind a load never stalls
        clrSide();
        drv(1'b0, 32'h124, 16'h0009, 5'd10, 32'hA0, 1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 1'b1, 1'b0);
        pushExp(1'b0, 32'h124, 16'h0009, 32'hA0, 32'h2, 5'd11, 1'b0, 1'b0);
        tick("invalid_nostall", 1'b0);

        // Reset mid-stream clears the register
        clrSide();
        drv(1'b1, 32'h128, 16'h000A, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 1'b1, 5'd12, 1'b1, 1'b1);
        rst = 1'b1;
        pushBubble();
        tick("mid_reset", 1'b0);

        // After reset, reading r12 does not stall since ex_valid=0
        clrSide();
        drv(1'b1, 32'h12C, 16'h000B, 5'd12, 32'hC0, 1'b1, 5'd0, 32'h1, 1'b0, 5'd13, 1'b1, 1'b0);
        pushExp(1'b1, 32'h12C, 16'h000B, 32'hC0, 32'h0, 5'd13, 1'b1, 1'b0);
        tick("post_reset", 1'b0);

        chk("queue_drained", 64'(q_exp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule : tb_id_ex_stage
`default_nettype wire
